// File: rtl/alu_unit.sv
// rtl/alu_unit.sv - ALU, registered flags and jump-condition driven program counter
// Optional ALU_SHIFT_BY_B_EN: shifts/rotates take their amount from b[2:0] instead of 1.
module alu_unit #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       opcode,
  output logic [WIDTH-1:0] alu_out,
  output logic [WIDTH-1:0] alu_flags,
  input  logic             flag_we,
  output logic [WIDTH-1:0] flags,
  input  logic [2:0]       jmp_sel,
  input  logic             jmp_pol,
  input  logic [WIDTH-1:0] imm,
  output logic             pl_e,
  output logic [WIDTH-1:0] pc
);

  logic [WIDTH-1:0] flags_q, flags_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic             ovf;
  logic [3:0]       amt;

`ifdef ALU_SHIFT_BY_B_EN
  assign amt = {1'b0, b[2:0]};
`else
  assign amt = 4'd1;
`endif

  always_comb begin
    res   = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    case (opcode[2:0])
      3'b000: begin
        if (opcode[3]) begin
          {carry, res} = {1'b0, a} - {1'b0, b};
          ovf = (a[7] != b[7]) && (res[7] != a[7]);
        end else begin
          {carry, res} = {1'b0, a} + {1'b0, b};
          ovf = (a[7] == b[7]) && (res[7] != a[7]);
        end
      end
      3'b001: res = a ^ b;
      3'b010: res = a & b;
      3'b011: res = opcode[3] ? ~(a | b) : (a | b);
      // Widened shifts leave the last bit shifted out in the spare position; it is 0 for amount 0.
      3'b100: {carry, res} = {1'b0, a} << amt;
      3'b101: {res, carry} = {a, 1'b0} >> amt;
      3'b110: begin
        res   = (a << amt) | (a >> (4'd8 - amt));
        carry = (amt != 4'd0) && res[0];
      end
      default: begin
        res   = (a >> amt) | (a << (4'd8 - amt));
        carry = (amt != 4'd0) && res[7];
      end
    endcase
  end

  assign alu_out   = res;
  assign alu_flags = {2'b00, ~^res, ovf, res[7], carry, (res == '0), 1'b0};

  // Jump condition looks only at the registered flags, so a same-edge write cannot affect it.
  assign pl_e = ~(flags_q[jmp_sel] ^ jmp_pol);

  always_comb begin
    flags_d = flag_we ? alu_flags : flags_q;
    pc_d    = pl_e ? imm : pc_q + 8'd1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      flags_q <= '0;
      pc_q    <= '0;
    end else begin
      flags_q <= flags_d;
      pc_q    <= pc_d;
    end
  end

  assign flags = flags_q;
  assign pc    = pc_q;

endmodule

// File: tb/tb_alu_unit.sv
// tb/tb_alu_unit.sv - self-checking bench for alu_unit with an arithmetic reference model
module tb_alu_unit;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] a, b, imm;
  logic [3:0] opcode;
  logic       flag_we, jmp_pol;
  logic [2:0] jmp_sel;
  logic [7:0] alu_out, alu_flags, flags, pc;
  logic       pl_e;

  int n_tests = 0;
  int n_fail  = 0;

  alu_unit #(.WIDTH(8)) dut (
    .CLK(CLK), .RST(RST), .a(a), .b(b), .opcode(opcode),
    .alu_out(alu_out), .alu_flags(alu_flags), .flag_we(flag_we), .flags(flags),
    .jmp_sel(jmp_sel), .jmp_pol(jmp_pol), .imm(imm), .pl_e(pl_e), .pc(pc)
  );

  always #5 CLK = ~CLK;

  function automatic logic [15:0] model_alu(input logic [7:0] x, input logic [7:0] y,
                                            input logic [3:0] op);
    int xi, yi, r, c, v, sx, sy, s, n_amt, ones;
    logic [7:0] rr, fl;
    xi = int'(x); yi = int'(y);
    sx = (xi > 127) ? xi - 256 : xi;
    sy = (yi > 127) ? yi - 256 : yi;
    r = 0; c = 0; v = 0;
    if (op == 4'd0) begin
      r = xi + yi; c = (r > 255) ? 1 : 0; s = sx + sy;
      v = (s > 127 || s < -128) ? 1 : 0; r = r % 256;
    end else if (op == 4'd8) begin
      r = (xi - yi + 256) % 256; c = (xi < yi) ? 1 : 0; s = sx - sy;
      v = (s > 127 || s < -128) ? 1 : 0;
    end else if (op[2:0] == 3'd1) r = int'(x ^ y);
    else if (op[2:0] == 3'd2) r = int'(x & y);
    else if (op == 4'd3) r = int'(x | y);
    else if (op == 4'd11) r = 255 - int'(x | y);
    else begin
`ifdef ALU_SHIFT_BY_B_EN
      n_amt = yi % 8;
`else
      n_amt = 1;
`endif
      r = xi;
      for (int k = 0; k < n_amt; k++) begin
        case (op[1:0])
          2'b00: begin c = r / 128; r = (r * 2) % 256; end
          2'b01: begin c = r % 2; r = r / 2; end
          2'b10: begin c = r / 128; r = (r * 2) % 256 + c; end
          default: begin c = r % 2; r = r / 2 + c * 128; end
        endcase
      end
    end
    ones = 0;
    for (int k = 0; k < 8; k++) ones += (r >> k) % 2;
    rr = r[7:0];
    fl = 8'h00;
    fl[1] = (r == 0);
    fl[2] = (c != 0);
    fl[3] = (r >= 128);
    fl[4] = (v != 0);
    fl[5] = (ones % 2 == 0);
    return {fl, rr};
  endfunction

  logic [15:0] m_alu;
  logic [7:0]  m_flags = 8'h00, m_pc = 8'h00;
  logic        m_ple;
  logic        started = 1'b0;

  always_comb m_alu = model_alu(a, b, opcode);
  always_comb m_ple = (((int'(m_flags) >> jmp_sel) % 2) == int'(jmp_pol));

  always @(posedge CLK) begin
    started <= 1'b1;
    if (RST) begin
      m_flags <= 8'h00;
      m_pc    <= 8'h00;
    end else begin
      m_pc <= m_ple ? imm : m_pc + 8'd1;
      if (flag_we) m_flags <= m_alu[15:8];
    end
  end

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (started) begin
      chk("model alu_out", alu_out, m_alu[7:0]);
      chk("model alu_flags", alu_flags, m_alu[15:8]);
      chk("model pl_e", {7'd0, pl_e}, {7'd0, m_ple});
      chk("model flags", flags, m_flags);
      chk("model pc", pc, m_pc);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic alu_vec(input string name, input logic [3:0] op, input logic [7:0] x,
                         input logic [7:0] y, input logic [7:0] e_out, input logic [7:0] e_fl);
    opcode = op; a = x; b = y;
    #1;
    chk({name, " out"}, alu_out, e_out);
    chk({name, " flags"}, alu_flags, e_fl);
    tick();
  endtask

  initial begin
    RST = 1'b1; a = 0; b = 0; imm = 0; opcode = 0;
    flag_we = 1'b0; jmp_sel = 3'd0; jmp_pol = 1'b1;
    tick(); tick();
    chk("reset pc", pc, 8'h00);
    chk("reset flags", flags, 8'h00);

    alu_vec("add 5+7", 4'b0000, 8'd5, 8'd7, 8'd12, 8'h20);
    alu_vec("add 12+9", 4'b0000, 8'd12, 8'd9, 8'd21, 8'h00);
    alu_vec("shl 21", 4'b0100, 8'd21, 8'd1, 8'd42, 8'h00);
    alu_vec("sub 5-7", 4'b1000, 8'd5, 8'd7, 8'd254, 8'h0C);
    alu_vec("add 127+1", 4'b0000, 8'd127, 8'd1, 8'd128, 8'h18);
    alu_vec("add 255+1", 4'b0000, 8'd255, 8'd1, 8'd0, 8'h26);
    alu_vec("xor", 4'b0001, 8'hF0, 8'h3C, 8'hCC, 8'h28);
    alu_vec("xor alt", 4'b1001, 8'hF0, 8'h3C, 8'hCC, 8'h28);
    alu_vec("and", 4'b0010, 8'hF0, 8'h3C, 8'h30, 8'h20);
    alu_vec("or", 4'b0011, 8'hF0, 8'h3C, 8'hFC, 8'h28);
    alu_vec("nor", 4'b1011, 8'hF0, 8'h3C, 8'h03, 8'h20);
    alu_vec("shl 81", 4'b0100, 8'h81, 8'd1, 8'h02, 8'h04);
    alu_vec("shr 81", 4'b0101, 8'h81, 8'd1, 8'h40, 8'h04);
    alu_vec("rol 81", 4'b0110, 8'h81, 8'd1, 8'h03, 8'h24);
    alu_vec("ror 81", 4'b1111, 8'h81, 8'd1, 8'hC0, 8'h2C);
`ifdef ALU_SHIFT_BY_B_EN
    alu_vec("rol 81 by 4", 4'b0110, 8'h81, 8'd4, 8'h18, 8'h20);
    alu_vec("shl 81 by 0", 4'b0100, 8'h81, 8'd0, 8'h81, 8'h28);
`endif

    jmp_sel = 3'd0; jmp_pol = 1'b0; imm = 8'h40; RST = 1'b0;
    tick();
    chk("jump always", pc, 8'h40);
    jmp_pol = 1'b1;
    tick(); tick(); tick();
    chk("sequential x3", pc, 8'h43);

    opcode = 4'b1000; a = 8'd7; b = 8'd7; flag_we = 1'b1;
    tick();
    chk("flags from 7-7", flags, 8'h22);
    chk("pc after flag write", pc, 8'h44);

    jmp_sel = 3'd1; jmp_pol = 1'b1; imm = 8'h10;
    opcode = 4'b0000; a = 8'd5; b = 8'd7; flag_we = 1'b1;
    #1;
    chk("pl_e on Z", {7'd0, pl_e}, 8'h01);
    tick();
    chk("jump on Z", pc, 8'h10);
    chk("flags same-edge", flags, 8'h20);
    chk("pl_e after new flags", {7'd0, pl_e}, 8'h00);
    flag_we = 1'b0;

    jmp_sel = 3'd0; jmp_pol = 1'b0; imm = 8'hFF;
    tick();
    chk("load ff", pc, 8'hFF);
    jmp_pol = 1'b1;
    tick();
    chk("wrap to 00", pc, 8'h00);

    for (int i = 0; i < 32; i++) begin
      opcode = 4'(i % 16); a = 8'(37 * i + 5); b = 8'(91 * i + 200);
      flag_we = (i % 3 != 0); jmp_sel = 3'(i % 8); jmp_pol = 1'(i / 2); imm = 8'(i * 11);
      tick();
    end

    jmp_sel = 3'd0; jmp_pol = 1'b0; imm = 8'h55;
    opcode = 4'b0000; a = 8'hFF; b = 8'h01; flag_we = 1'b1; RST = 1'b1;
    tick();
    chk("reset beats load", pc, 8'h00);
    chk("reset drops flag write", flags, 8'h00);
    RST = 1'b0;
    tick();
    chk("load after reset", pc, 8'h55);
    #5;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_unit.md
Name: alu_unit

Overview:
- 8-bit datapath/sequencer slice built from three parts:
  - a combinational ALU with a 4-bit opcode,
  - a registered 8-bit flag register,
  - a flag-select jump-condition mux (bitmux8 function) driving an 8-bit program counter with increment/parallel-load (byteIncrementer function).
- Sits between the register bank (supplies operands A/B) and instruction memory (addressed by pc).

Parameters:
- WIDTH, 8, datapath, flag and pc width; only 8 is supported.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-high reset.
- a  input  8  ALU operand A.
- b  input  8  ALU operand B (register or immediate, muxed externally).
- opcode  input  4  ALU operation select.
- alu_out  output  8  combinational ALU result.
- alu_flags  output  8  combinational flags of the current operation.
- flag_we  input  1  flag register write enable.
- flags  output  8  registered flags.
- jmp_sel  input  3  selects the flags bit used as jump condition.
- jmp_pol  input  1  jump polarity.
- imm  input  8  jump target / parallel-load address.
- pl_e  output  1  parallel-load enable (jump taken), combinational.
- pc  output  8  program counter (instruction address).

Behaviour:
- ALU opcodes; x = don't care. Operands are unsigned 8-bit and the result is truncated to 8 bits.
  - 0000 ADD: a+b.
  - 1000 SUB: a-b.
  - x001 XOR.
  - x010 AND.
  - 0011 OR.
  - 1011 NOR.
  - x100 SHL: a<<1, zero fill.
  - x101 SHR: a>>1, logical.
  - x110 ROL by 1.
  - x111 ROR by 1.
- Operand b is ignored for shifts and rotates.
- alu_flags bit map:
  - [0] constant 0 ("never").
  - [1] Z: result==0.
  - [2] C:
    - ADD: carry-out.
    - SUB: borrow, 1 iff a<b unsigned.
    - SHL/ROL: old a[7].
    - SHR/ROR: old a[0].
    - Logic ops: 0.
  - [3] N: result[7].
  - [4] V: signed overflow for ADD/SUB, 0 otherwise.
  - [5] P: 1 iff result has an even number of ones.
  - [7:6] reserved, 0.
- flags register:
  - RST → 0x00.
  - Otherwise, on the rising edge with flag_we=1, flags <= alu_flags.
  - Holds when flag_we=0.
- Jump condition:
  - pl_e = ~(flags[jmp_sel] ^ jmp_pol), so a jump is taken when the selected bit equals jmp_pol.
  - It uses the registered flags, never alu_flags.
  - jmp_sel=0 with jmp_pol=0 is an unconditional jump.
  - jmp_sel=0 with jmp_pol=1 is "never jump" (sequential).
- PC:
  - RST → 0x00; RST has priority over pl_e.
  - Otherwise each rising edge: pc <= pl_e ? imm : pc+1.
  - pc+1 wraps 0xFF→0x00 with no flag effect.
  - There is no stall; the pc advances every cycle.
- Same-edge write and jump: if flag_we=1 and a jump is evaluated on the same edge, the jump uses the pre-edge flags value. The new flags are visible from the next cycle.
- Latency:
  - alu_out, alu_flags, pl_e: 0 cycles, combinational.
  - flags, pc: 1 cycle.
- Reset mid-operation: the pending flag write and pc load are discarded and both registers read 0x00 after the edge.

Optional Feature:
- Macro ALU_SHIFT_BY_B_EN.
- When defined:
  - SHL/SHR/ROL/ROR use shift amount b[2:0]. b[7:3] is ignored.
  - Amount 0 gives result=a, C=0.
  - Otherwise C = the last bit shifted or rotated out.
- When undefined: the amount is fixed at 1 and b is ignored for these opcodes.
- All other behaviour is identical in both builds.

Test Plan:
- ADD a=5 b=7 → alu_out=12, Z=0 C=0 N=0 V=0. Then ADD a=12 b=9 → 21. Then SHL a=21 → 42, C=0.
- SUB a=5 b=7 → 254, C=1 N=1 V=0. ADD a=127 b=1 → 128, N=1 V=1. ADD a=255 b=1 → 0, Z=1 C=1 P=1.
- Each logic op with a=0xF0 b=0x3C:
  - XOR → 0xCC.
  - AND → 0x30.
  - OR → 0xFC.
  - NOR → 0x03.
  - All with C=V=0.
- Shift/rotate with a=0x81 (default build):
  - SHL → 0x02, C=1.
  - SHR → 0x40, C=1.
  - ROL → 0x03.
  - ROR → 0xC0.
- ALU_SHIFT_BY_B_EN build, a=0x81:
  - ROL b=4 → 0x18.
  - SHL b=0 → 0x81, C=0.
- PC and jump:
  - Assert RST → pc=0, flags=0.
  - jmp_sel=0 jmp_pol=0 imm=0x40 → pc=0x40.
  - jmp_pol=1 for 3 cycles → pc=0x43.
  - Write flags from SUB 7-7 (Z=1), then jmp_sel=1 jmp_pol=1 imm=0x10 → pc=0x10 next edge.
  - Load imm=0xFF then sequential → 0x00.
  - Assert RST while pl_e=1 → pc=0x00.
